// File: rtl/ram_if.sv
// Bus/control bundle for the SAP-style 16x8 RAM.
// Front-panel switches, control lines and bus data in one interface.
`timescale 1ns/1ps
interface ram_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] dipswitch_data;
  logic [ADDR_W-1:0] dipswitch_addr;
  logic [DATA_W-1:0] bus_in;
  logic              addr_select;
  logic              prog_mode;
  logic              bus_enable_n;
  logic              write_enable;
  logic              control_signal;
  logic              load_mar_reg_n;
  logic [DATA_W-1:0] bus_out;

  modport master (
    output dipswitch_data,
    output dipswitch_addr,
    output bus_in,
    output addr_select,
    output prog_mode,
    output bus_enable_n,
    output write_enable,
    output control_signal,
    output load_mar_reg_n,
    input  bus_out
  );

  modport slave (
    input  dipswitch_data,
    input  dipswitch_addr,
    input  bus_in,
    input  addr_select,
    input  prog_mode,
    input  bus_enable_n,
    input  write_enable,
    input  control_signal,
    input  load_mar_reg_n,
    output bus_out
  );
endinterface

// File: rtl/ram.sv
// 16x8 program/data RAM with integrated MAR for the SAP computer.
// Manual writes are level-sensitive latches; run writes are clocked.
`timescale 1ns/1ps
module ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic clear_mar_reg_n,
  ram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] r_mar;

  // Two storage banks: one written by the manual latch path,
  // one by the clocked run path. A per-word XOR flag pair
  // records which bank holds the most recent write, so each
  // storage bit keeps exactly one driver.
  logic [DEPTH-1:0][DATA_W-1:0] r_prog_mem;
  logic [DEPTH-1:0][DATA_W-1:0] r_run_mem;
  logic [DEPTH-1:0]             r_lvt_prog;
  logic [DEPTH-1:0]             r_lvt_run;

  logic [ADDR_W-1:0] w_mar_src;
  logic [DATA_W-1:0] w_wdata;
  logic              w_prog_we;
  logic              w_run_we;
  logic              w_sel_run;
  logic [DATA_W-1:0] w_rdata;

  // Source muxes and write qualifiers
  always_comb begin
    w_mar_src = bus.addr_select ? bus.bus_in[ADDR_W-1:0]
                                : bus.dipswitch_addr;
    w_wdata   = bus.prog_mode ? bus.bus_in : bus.dipswitch_data;
    w_prog_we = ~bus.prog_mode & bus.write_enable;
    w_run_we  = bus.prog_mode & bus.control_signal;
  end

  // MAR: async clear wins over load
  always_ff @(posedge clk or negedge clear_mar_reg_n) begin
    if (!clear_mar_reg_n) begin
      r_mar <= '0;
    end else if (!bus.load_mar_reg_n) begin
      r_mar <= w_mar_src;
    end
  end

  // Manual write: transparent while the push-button is held
  always_latch begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_prog_we && (r_mar == ADDR_W'(i))) begin
        r_prog_mem[i] <= w_wdata;
        r_lvt_prog[i] <= r_lvt_run[i];
      end
    end
  end

  // Run write: uses the MAR value from before this edge
  always_ff @(posedge clk) begin
    if (w_run_we) begin
      r_run_mem[r_mar] <= w_wdata;
      r_lvt_run[r_mar] <= ~r_lvt_prog[r_mar];
    end
  end

  // Read: pick the bank that saw the latest write
  always_comb begin
    w_sel_run   = r_lvt_run[r_mar] ^ r_lvt_prog[r_mar];
    w_rdata     = w_sel_run ? r_run_mem[r_mar] : r_prog_mem[r_mar];
    bus.bus_out = bus.bus_enable_n ? '0 : w_rdata;
  end

endmodule

// File: tb/tb_ram.sv
// Randomized self-checking bench for the SAP RAM.
// Array model of memory plus MAR, checked on every falling edge.
`timescale 1ns/1ps
module tb_ram;
  logic clk;
  logic rst_n;

  ram_if #(.ADDR_W(4), .DATA_W(8)) u_if ();

  ram #(.ADDR_W(4), .DATA_W(8)) u_dut (
    .clk             (clk),
    .clear_mar_reg_n (rst_n),
    .bus             (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_mem [16];
  bit         m_valid [16];
  int unsigned m_mar = 0;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: bus_out=%02h expected=%02h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: clocked behaviour at each rising edge
  always @(posedge clk) begin
    if (u_if.prog_mode && u_if.control_signal) begin
      m_mem[m_mar]   = u_if.bus_in;
      m_valid[m_mar] = 1'b1;
    end
    if (!rst_n)
      m_mar = 0;
    else if (!u_if.load_mar_reg_n)
      m_mar = u_if.addr_select ? int'(u_if.bus_in[3:0])
                               : int'(u_if.dipswitch_addr);
  end

  // Compare DUT output against model mid-cycle
  always @(negedge clk) begin
    if (u_if.bus_enable_n)
      check("idle_zero", u_if.bus_out, 8'h00);
    else if (m_valid[m_mar])
      check("read", u_if.bus_out, m_mem[m_mar]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // 1 ns manual write pulse, placed between clock edges
  task automatic prog_pulse(logic [7:0] data);
    u_if.dipswitch_data = data;
    #1 u_if.write_enable = 1'b1;
    #1 u_if.write_enable = 1'b0;
    if (!u_if.prog_mode) begin
      m_mem[m_mar]   = data;
      m_valid[m_mar] = 1'b1;
    end
  endtask

  initial begin
    rst_n                 = 1'b0;
    u_if.dipswitch_data   = '0;
    u_if.dipswitch_addr   = '0;
    u_if.bus_in           = '0;
    u_if.addr_select      = 1'b0;
    u_if.prog_mode        = 1'b0;
    u_if.bus_enable_n     = 1'b1;
    u_if.write_enable     = 1'b0;
    u_if.control_signal   = 1'b0;
    u_if.load_mar_reg_n   = 1'b1;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

    step();
    check("reset_idle", u_if.bus_out, 8'h00);
    step();
    rst_n = 1'b1;

    // Manual write at address 0 after reset
    u_if.bus_enable_n = 1'b0;
    prog_pulse(8'hA5);
    check("wr_a5", u_if.bus_out, 8'hA5);

    // MAR from DIP switches -> 10
    step();
    u_if.addr_select    = 1'b0;
    u_if.dipswitch_addr = 4'b1010;
    u_if.load_mar_reg_n = 1'b0;
    step();
    u_if.load_mar_reg_n = 1'b1;
    prog_pulse(8'b11001111);
    check("man_cf", u_if.bus_out, 8'hCF);
    step();
    u_if.bus_enable_n = 1'b1;
    #1 check("man_off", u_if.bus_out, 8'h00);

    // MAR from bus low nibble -> 7
    step();
    u_if.bus_enable_n   = 1'b0;
    u_if.addr_select    = 1'b1;
    u_if.bus_in         = 8'b11110111;
    u_if.load_mar_reg_n = 1'b0;
    step();
    u_if.load_mar_reg_n = 1'b1;

    // Run write 3C, then a non-write with 55
    u_if.prog_mode      = 1'b1;
    u_if.bus_in         = 8'h3C;
    u_if.control_signal = 1'b1;
    step();
    u_if.control_signal = 1'b0;
    u_if.bus_in         = 8'h55;
    #1 check("run_3c", u_if.bus_out, 8'h3C);
    step();
    #1 check("run_hold", u_if.bus_out, 8'h3C);

    // Mode isolation
    prog_pulse(8'h99);
    check("iso_we", u_if.bus_out, 8'h3C);
    step();
    u_if.prog_mode      = 1'b0;
    u_if.control_signal = 1'b1;
    u_if.bus_in         = 8'h11;
    step();
    u_if.control_signal = 1'b0;
    #1 check("iso_ctl", u_if.bus_out, 8'h3C);

    // Run write and MAR load on the same edge
    u_if.prog_mode      = 1'b1;
    u_if.control_signal = 1'b1;
    u_if.bus_in         = 8'hE2;
    u_if.addr_select    = 1'b0;
    u_if.dipswitch_addr = 4'd10;
    u_if.load_mar_reg_n = 1'b0;
    step();
    u_if.control_signal = 1'b0;
    u_if.load_mar_reg_n = 1'b1;
    #1 check("simul_new", u_if.bus_out, 8'hCF);
    u_if.addr_select    = 1'b1;
    u_if.bus_in         = 8'h07;
    u_if.load_mar_reg_n = 1'b0;
    step();
    u_if.load_mar_reg_n = 1'b1;
    #1 check("simul_old", u_if.bus_out, 8'hE2);

    // Mid-cycle async clear of MAR
    u_if.prog_mode = 1'b0;
    step();
    rst_n = 1'b0;
    m_mar = 0;
    #1 check("reset_async", u_if.bus_out, 8'hA5);
    #1 rst_n = 1'b1;
    step();
    prog_pulse(8'h5A);
    check("reset_wr", u_if.bus_out, 8'h5A);

    // Randomized traffic
    repeat (400) begin
      int r;
      step();
      u_if.dipswitch_addr = 4'($urandom_range(0, 15));
      u_if.bus_in         = 8'($urandom_range(0, 255));
      u_if.addr_select    = 1'($urandom_range(0, 1));
      u_if.load_mar_reg_n = 1'($urandom_range(0, 1));
      u_if.prog_mode      = 1'($urandom_range(0, 1));
      u_if.control_signal = 1'($urandom_range(0, 1));
      u_if.bus_enable_n   = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 7));
      if (r < 3) begin
        prog_pulse(8'($urandom_range(0, 255)));
      end else if (r == 3) begin
        #1 rst_n = 1'b0;
        m_mar = 0;
        #1 rst_n = 1'b1;
      end
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
